// File: rtl/fma16_normalize.sv
// Leading-one normalizer for the fp16 FMA datapath: coarse/fine left-shift FSM
// between the adder/alignment stage and the rounder, with valid/ready on both sides.
module fma16_normalize #(
    parameter int IN_W = 48,
    parameter int STEP = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_sign,
    input  logic [6:0]      in_exp,
    input  logic [IN_W-1:0] in_mant,
    input  logic            in_sticky,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            Ss,
    output logic [6:0]      Se,
    output logic [35:0]     Sm,
    output logic            ASticky,
    output logic            zero
);

    localparam logic [6:0] STEP_E = 7'(STEP);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   m_q, m_d;
    logic [6:0]        e_q, e_d;
    logic              sign_q, sign_d;
    logic              sticky_q, sticky_d;

    logic              ss_q, ss_d;
    logic [6:0]        se_q, se_d;
    logic [35:0]       sm_q, sm_d;
    logic              asticky_q, asticky_d;
    logic              zero_q, zero_d;
    logic              ovalid_q, ovalid_d;

    logic              stop;
    logic              coarse;
    logic              low_or;

    // Exponent handed to the rounder: zero mantissa or an unfinished shift at e==1 is subnormal.
    function automatic logic [6:0] out_exp(input logic [IN_W-1:0] m, input logic [6:0] e);
        if (m == '0 || (e == 7'd1 && !m[IN_W-1]))
            return 7'd0;
        return e;
    endfunction

    generate
        if (IN_W > 36) begin : g_low
            assign low_or = |m_q[IN_W-37:0];
        end else begin : g_nolow
            assign low_or = 1'b0;
        end
    endgenerate

    assign stop   = m_q[IN_W-1] || (m_q == '0) || (e_q == 7'd1);
    assign coarse = (m_q[IN_W-1 -: STEP] == '0) && (e_q > STEP_E);

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        e_d       = e_q;
        sign_d    = sign_q;
        sticky_d  = sticky_q;
        ss_d      = ss_q;
        se_d      = se_q;
        sm_d      = sm_q;
        asticky_d = asticky_q;
        zero_d    = zero_q;
        ovalid_d  = ovalid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d      = in_mant;
                    e_d      = in_exp;
                    sign_d   = in_sign;
                    sticky_d = in_sticky;
                    state_d  = NORM;
                end
            end
            NORM: begin
                if (stop) begin
                    ss_d      = sign_q;
                    se_d      = out_exp(m_q, e_q);
                    sm_d      = m_q[IN_W-1 -: 36];
                    asticky_d = sticky_q | low_or;
                    zero_d    = (m_q == '0) & ~sticky_q;
                    ovalid_d  = 1'b1;
                    state_d   = DONE;
                end else if (coarse) begin
                    m_d = m_q << STEP;
                    e_d = e_q - STEP_E;
                end else begin
                    m_d = m_q << 1;
                    e_d = e_q - 7'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    ovalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and rounder-facing registers; reset clears them and drops any in-flight operand.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ss_q      <= 1'b0;
            se_q      <= 7'd0;
            sm_q      <= 36'd0;
            asticky_q <= 1'b0;
            zero_q    <= 1'b0;
            ovalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ss_q      <= ss_d;
            se_q      <= se_d;
            sm_q      <= sm_d;
            asticky_q <= asticky_d;
            zero_q    <= zero_d;
            ovalid_q  <= ovalid_d;
        end
    end

    // Working registers are only meaningful in NORM, so they carry no reset.
    always_ff @(posedge clk) begin
        m_q      <= m_d;
        e_q      <= e_d;
        sign_q   <= sign_d;
        sticky_q <= sticky_d;
    end

    assign in_ready  = (state_q == IDLE) & ~reset;
    assign out_valid = ovalid_q;
    assign Ss        = ss_q;
    assign Se        = se_q;
    assign Sm        = sm_q;
    assign ASticky   = asticky_q;
    assign zero      = zero_q;

endmodule
